axis_mem_arbiter: RTL
=====================

Name: axis_mem_arbiter

Overview:
- Two-requester, packet-granular round-robin arbiter placed in front of the memory wrapper's AXI-Stream slave port.
- Lets two producers (for example, a host loader and a DMA engine) share a single memory write/read path.
- Once a requester is granted, the grant stays locked until that requester's tlast beat is accepted, so packets are never interleaved.
- The output is a registered pipeline stage with one beat of storage.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; tstrb width is DATA_WIDTH/8.

Ports:
- axis_aclk  input  1  single clock for all ports
- axis_aresetn  input  1  synchronous, active-low reset, sampled on the rising edge of axis_aclk
- s01_axis_tdata  input  DATA_WIDTH  requester 0 data
- s01_axis_tstrb  input  DATA_WIDTH/8  requester 0 byte strobes
- s01_axis_tvalid  input  1  requester 0 valid
- s01_axis_tlast  input  1  requester 0 end of packet
- s01_axis_tready  output  1  requester 0 ready
- s02_axis_tdata  input  DATA_WIDTH  requester 1 data
- s02_axis_tstrb  input  DATA_WIDTH/8  requester 1 byte strobes
- s02_axis_tvalid  input  1  requester 1 valid
- s02_axis_tlast  input  1  requester 1 end of packet
- s02_axis_tready  output  1  requester 1 ready
- m01_axis_tready  input  1  downstream (memory wrapper) ready
- m01_axis_tdata  output  DATA_WIDTH  arbitrated data, registered
- m01_axis_tstrb  output  DATA_WIDTH/8  arbitrated strobes, registered
- m01_axis_tvalid  output  1  arbitrated valid, registered
- m01_axis_tlast  output  1  arbitrated last, registered
- grant  output  2  one-hot current owner (bit0 = s01, bit1 = s02); 2'b00 when idle

Behaviour:
- Reset (axis_aresetn = 0 at a clock edge):
  - state = IDLE, grant = 00, last_owner = 1 (so s01 wins the first contention).
  - m01_axis_tvalid/tlast = 0, m01_axis_tdata/tstrb = 0, both s0x_axis_tready = 0.
  - Reset mid-packet abandons the packet; no beat is emitted after reset. The requester must restart its packet.
- States: IDLE, BUSY.
- IDLE:
  - Both tready = 0.
  - If exactly one s0x tvalid = 1, grant that port.
  - If both tvalid = 1, grant the port that is not last_owner.
  - If neither, stay IDLE.
  - On a grant: next state = BUSY, grant register updated. Arbitration costs exactly one cycle.
  - tlast/tdata of a non-granted port are ignored.
- BUSY:
  - s_rdy = !m01_axis_tvalid || m01_axis_tready.
  - Granted port's tready = s_rdy; the other port's tready = 0.
  - Beat accept: granted tvalid && tready. On accept, tdata/tstrb/tlast are loaded into the output register and m01_axis_tvalid = 1 next cycle. Latency is 1 cycle from accept to appearance on m01.
  - Output drains when m01_axis_tvalid && m01_axis_tready with no new accept in the same cycle; then m01_axis_tvalid = 0 next cycle.
  - Drain and accept in the same cycle: register reloads and valid stays 1. Full throughput is 1 beat/cycle while m01_axis_tready = 1.
  - Accepted beat with tlast = 1: next state = IDLE, last_owner = granted port, grant = 00. The tlast beat may still be held in the output register and drains normally.
- Back-to-back packets: minimum one-cycle bubble on the slave side between tlast accept and the next packet's first accept.
- AXI rules:
  - m01_axis_tvalid, once 1, is never deasserted until m01_axis_tready = 1.
  - Output data is stable while tvalid = 1 and tready = 0.
  - tready never depends combinationally on the same port's tvalid.
- Downstream stall (m01_axis_tready = 0, output full): granted tready = 0 and the owner keeps its grant indefinitely; there is no timeout.
- Single-beat packet (tvalid and tlast on the first beat): BUSY lasts exactly one accept cycle.
- A tstrb of all zeros is passed through unmodified; the arbiter never interprets data.

Test Plan:
- Single requester: s01 sends 3 beats A0, A1, A2 (tlast on A2) with m01_axis_tready = 1 → grant = 01 from cycle 1. m01 shows A0, A1, A2 on consecutive cycles with tlast only on A2. grant returns to 00 after the A2 accept.
- Contention after reset: s01 and s02 both present 2-beat packets on the same cycle → s01 packet fully out first, then s02. No interleaving; tlast appears exactly twice.
- Round-robin fairness: both requesters stream 1-beat packets continuously for 8 packets → m01 order alternates s01, s02, s01, …, giving 4 packets each.
- Backpressure: m01_axis_tready toggles 1,0,0,1 during a 4-beat s02 packet → s02_axis_tready = 0 while the output is full. Data D0..D3 is held stable under stall, with no loss or duplication. s01_axis_tready stays 0 throughout.
- Reset mid-packet: assert axis_aresetn = 0 after beat 2 of 4 from s01 → the next cycle shows m01_axis_tvalid = 0 and grant = 00. A following s02 packet wins arbitration normally after reset is released.
- Ignore non-granted tlast: s02 asserts tvalid/tlast while s01 is mid-packet → no state change. s02 is granted only after s01's tlast is accepted.

Source files
------------

// File: rtl/axis_mem_arbiter.sv
// Two-requester AXI-Stream arbiter with packet-granular round-robin and one registered
// output beat. The grant is held from a packet's first beat until its tlast beat is accepted.
module axis_mem_arbiter #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                      axis_aclk,
   input  logic                      axis_aresetn,
   input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
   input  logic                      s01_axis_tvalid,
   input  logic                      s01_axis_tlast,
   output logic                      s01_axis_tready,
   input  logic [DATA_WIDTH-1:0]     s02_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s02_axis_tstrb,
   input  logic                      s02_axis_tvalid,
   input  logic                      s02_axis_tlast,
   output logic                      s02_axis_tready,
   input  logic                      m01_axis_tready,
   output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
   output logic                      m01_axis_tvalid,
   output logic                      m01_axis_tlast,
   output logic [1:0]                grant
);

   typedef enum logic {StIdle, StBusy} state_t;

   state_t                    r_state, w_state_d;
   logic [1:0]                r_grant, w_grant_d;
   logic                      r_last_owner, w_last_owner_d;  // 0 = s01, 1 = s02
   logic [DATA_WIDTH-1:0]     r_tdata;
   logic [DATA_WIDTH/8-1:0]   r_tstrb;
   logic                      r_tvalid;
   logic                      r_tlast;

   logic                      w_s_rdy;
   logic                      w_in_valid;
   logic                      w_in_last;
   logic [DATA_WIDTH-1:0]     w_in_data;
   logic [DATA_WIDTH/8-1:0]   w_in_strb;
   logic                      w_accept;

   // The output slot can take a new beat if it is empty or draining this cycle.
   assign w_s_rdy    = !r_tvalid || m01_axis_tready;
   assign w_in_valid = r_grant[1] ? s02_axis_tvalid : s01_axis_tvalid;
   assign w_in_last  = r_grant[1] ? s02_axis_tlast  : s01_axis_tlast;
   assign w_in_data  = r_grant[1] ? s02_axis_tdata  : s01_axis_tdata;
   assign w_in_strb  = r_grant[1] ? s02_axis_tstrb  : s01_axis_tstrb;
   assign w_accept   = (r_state == StBusy) && w_in_valid && w_s_rdy;

   assign s01_axis_tready = (r_state == StBusy) && r_grant[0] && w_s_rdy;
   assign s02_axis_tready = (r_state == StBusy) && r_grant[1] && w_s_rdy;

   always_comb begin
      w_state_d      = r_state;
      w_grant_d      = r_grant;
      w_last_owner_d = r_last_owner;
      unique case (r_state)
         StIdle: begin
            if (s01_axis_tvalid && (!s02_axis_tvalid || r_last_owner)) begin
               w_state_d = StBusy;
               w_grant_d = 2'b01;
            end else if (s02_axis_tvalid) begin
               w_state_d = StBusy;
               w_grant_d = 2'b10;
            end
         end
         StBusy: begin
            if (w_accept && w_in_last) begin
               w_state_d      = StIdle;
               w_grant_d      = 2'b00;
               w_last_owner_d = r_grant[1];
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         r_state      <= StIdle;
         r_grant      <= 2'b00;
         r_last_owner <= 1'b1;
         r_tdata      <= '0;
         r_tstrb      <= '0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_grant      <= w_grant_d;
         r_last_owner <= w_last_owner_d;
         if (w_accept) begin
            r_tdata  <= w_in_data;
            r_tstrb  <= w_in_strb;
            r_tlast  <= w_in_last;
            r_tvalid <= 1'b1;
         end else if (r_tvalid && m01_axis_tready) begin
            r_tvalid <= 1'b0;
         end
      end
   end

   assign m01_axis_tdata  = r_tdata;
   assign m01_axis_tstrb  = r_tstrb;
   assign m01_axis_tvalid = r_tvalid;
   assign m01_axis_tlast  = r_tlast;
   assign grant           = r_grant;

endmodule
